// File: rtl/serial_alu_seq.sv
// Multi-cycle ALU: processes a WIDTH-bit operand pair SLICE bits per clock, LSB slice first,
// with a rippled carry register, start/busy/done handshake and registered result and flags.
module serial_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             Pin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             P,
    output logic             ovf,
    output logic             zero
);
    localparam int STEPS  = WIDTH / SLICE;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if ((SLICE < 1) || (SLICE > WIDTH) || (WIDTH % SLICE != 0)) begin : g_bad_params
            $error("serial_alu_seq: WIDTH must be a multiple of SLICE and 1 <= SLICE <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [3:0]        s_q;
    logic              m_q;
    logic              carry;
    logic [STEP_W-1:0] step;

    int unsigned       base;
    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  a_sel;
    logic [SLICE-1:0]  b_sel;
    logic [SLICE-1:0]  logic_r;
    logic [SLICE-1:0]  r_sl;
    logic [SLICE:0]    sum;
    logic              c_out;
    logic              c_msb;
    logic              last;
    logic [WIDTH-1:0]  r_next;

    // One slice of the datapath, selected by the step counter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        logic_r = '0;
        base    = 32'(step) * 32'(SLICE);
        a_sl    = SLICE'(a_q >> base);
        b_sl    = SLICE'(b_q >> base);

        a_sel = s_q[3] ? '0 : a_sl;
        case (s_q[1:0])
            2'b00:   b_sel = '0;
            2'b01:   b_sel = b_sl;
            2'b10:   b_sel = ~b_sl;
            default: b_sel = '1;
        endcase

        sum   = {1'b0, a_sel} + {1'b0, b_sel} + {{SLICE{1'b0}}, carry};
        c_out = sum[SLICE];
        // Carry into the slice MSB recovered from its sum bit and operand bits.
        c_msb = sum[SLICE-1] ^ a_sel[SLICE-1] ^ b_sel[SLICE-1];

        for (int i = 0; i < SLICE; i++) begin
            logic_r[i] = s_q[{a_sl[i], b_sl[i]}];
        end

        r_sl   = m_q ? logic_r : sum[SLICE-1:0];
        r_next = R | (WIDTH'(r_sl) << base);
        last   = (step == STEP_W'(STEPS - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            m_q   <= 1'b0;
            carry <= 1'b0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            R     <= '0;
            P     <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        s_q   <= S;
                        m_q   <= M;
                        carry <= Pin & ~M;
                        step  <= '0;
                        R     <= '0;
                        P     <= 1'b0;
                        ovf   <= 1'b0;
                        zero  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    R     <= r_next;
                    carry <= c_out & ~m_q;
                    step  <= step + STEP_W'(1);
                    if (last) begin
                        P     <= c_out & ~m_q;
                        ovf   <= (c_msb ^ c_out) & ~m_q;
                        zero  <= (r_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
